// File: rtl/muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the multiply/divide sequencer:
//   - MD_OP_* 3-bit operation codes, also used by the decode stage
//   - MD_CNT_W, the width of the latency counter
//   - the IDLE/RUN state type and the packed result record that the
//     combinational calculator hands back to the controller
//   - isMultOp/isDivOp helpers so that op groups are decoded in one place
// ---------------------------------------------------------------------------
package muldiv_ctrl_pkg;

   localparam int MD_CNT_W = 8;

   localparam logic [2:0] MD_OP_MULT  = 3'd1;
   localparam logic [2:0] MD_OP_MULTU = 3'd2;
   localparam logic [2:0] MD_OP_DIV   = 3'd3;
   localparam logic [2:0] MD_OP_DIVU  = 3'd4;
   localparam logic [2:0] MD_OP_MTHI  = 3'd5;
   localparam logic [2:0] MD_OP_MTLO  = 3'd6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdState_t;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        divByZero;
   } mdResult_t;

   function automatic logic isMultOp(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
   endfunction

   function automatic logic isDivOp(input logic [2:0] op);
      return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_if
// Groups the handshake between the E/D pipeline stages and the mult/div unit.
//   start      E-stage instruction is an MD op (one-cycle qualifier)
//   op         MD_OP_* code
//   rs_data    forwarded rs operand (dividend / multiplicand / MTxx source)
//   rt_data    forwarded rt operand (divisor / multiplier)
//   d_uses_md  D-stage instruction reads or writes HI/LO
//   busy       multi-cycle operation in progress
//   md_stall   stall request to the hazard unit
//   hi, lo     architectural HI/LO registers
// The pipeline side takes the master modport, the unit takes slave.
// ---------------------------------------------------------------------------
interface muldiv_ctrl_if;

   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        d_uses_md;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_data, rt_data, d_uses_md,
      input  busy, md_stall, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data, d_uses_md,
      output busy, md_stall, hi, lo
   );

endinterface

// File: rtl/muldiv_ctrl_calc.sv
// ---------------------------------------------------------------------------
// muldiv_calc
// Purely combinational arithmetic for the mult/div unit.
//   i_op   MD_OP_* code of the latched operation
//   i_a    latched rs operand
//   i_b    latched rt operand
//   o_res  {hi, lo, divByZero}: the value HI/LO take at commit
// Signed division is done on magnitudes, and the signs are fixed up afterwards.
// This truncates the quotient toward zero and gives the remainder the
// dividend's sign. 0x80000000 / -1 then wraps naturally to 0x80000000, rem 0.
// ---------------------------------------------------------------------------
module muldiv_calc
   import muldiv_ctrl_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output mdResult_t   o_res
);

   logic [63:0] w_extA;
   logic [63:0] w_extB;
   logic [63:0] w_prod;
   logic [31:0] w_magA;
   logic [31:0] w_magB;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic        w_signed;

   // The multiply is formed on sign- or zero-extended 64-bit operands, so one
   // multiplier covers MULT and MULTU. For division a zero divisor is replaced
   // by 1. This keeps the datapath X-free, and the controller discards the
   // result anyway.
   always_comb begin
      o_res    = '0;
      w_signed = (i_op == MD_OP_MULT) || (i_op == MD_OP_DIV);
      w_extA   = {{32{w_signed & i_a[31]}}, i_a};
      w_extB   = {{32{w_signed & i_b[31]}}, i_b};
      w_prod   = w_extA * w_extB;

      w_magA   = (w_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
      w_magB   = (w_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;
      if (w_magB == 32'd0) begin
         w_magB = 32'd1;
      end
      w_quot   = w_magA / w_magB;
      w_rem    = w_magA % w_magB;

      o_res.divByZero = isDivOp(i_op) && (i_b == 32'd0);

      if (isMultOp(i_op)) begin
         o_res.hi = w_prod[63:32];
         o_res.lo = w_prod[31:0];
      end else if (i_op == MD_OP_DIVU) begin
         o_res.hi = w_rem;
         o_res.lo = w_quot;
      end else if (i_op == MD_OP_DIV) begin
         o_res.lo = (i_a[31] ^ i_b[31]) ? (~w_quot + 32'd1) : w_quot;
         o_res.hi = i_a[31] ? (~w_rem + 32'd1) : w_rem;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
// Multi-cycle multiply/divide sequencer that owns HI/LO and sits beside the
// E stage.
//   clk     clock
//   reset   synchronous, active-high reset
//   md      muldiv_ctrl_if.slave (start/op/rs_data/rt_data/d_uses_md in,
//           busy/md_stall/hi/lo out)
// Parameters: MUL_CYCLES (1..255), DIV_CYCLES (1..255) busy cycles.
// Optional macro MULDIV_TRACE_EN enables the following simulation messages:
//   - a message on every HI/LO commit
//   - a warning when start arrives while the unit is busy
// Cycle behaviour is identical whether or not the macro is defined.
// ---------------------------------------------------------------------------
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
)(
   input  logic          clk,
   input  logic          reset,
   muldiv_ctrl_if.slave  md
);

   logic [MD_CNT_W-1:0] r_cnt;
   logic [2:0]          r_op;
   logic [31:0]         r_a;
   logic [31:0]         r_b;
   logic [31:0]         r_hi;
   logic [31:0]         r_lo;

   logic [MD_CNT_W-1:0] w_cntNext;
   logic [2:0]          w_opNext;
   logic [31:0]         w_aNext;
   logic [31:0]         w_bNext;
   logic [31:0]         w_hiNext;
   logic [31:0]         w_loNext;
   logic                w_commit;
   logic                w_busy;
   mdState_t            w_state;
   mdResult_t           w_res;

   // The arithmetic only sees the latched operands, never the live buses.
   muldiv_calc u_calc (
      .i_op  (r_op),
      .i_a   (r_a),
      .i_b   (r_b),
      .o_res (w_res)
   );

   // The counter is the state: any non-zero count means an operation is
   // in flight.
   assign w_state     = (r_cnt != '0) ? ST_RUN : ST_IDLE;
   assign w_busy      = (w_state == ST_RUN);
   assign md.busy     = w_busy;
   assign md.md_stall = md.d_uses_md && (w_busy || md.start);
   assign md.hi       = r_hi;
   assign md.lo       = r_lo;

   // State register plus operand and HI/LO latches. A reset clears the count
   // along with everything else, which drops any pending result.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_op  <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
      end else begin
         r_cnt <= w_cntNext;
         r_op  <= w_opNext;
         r_a   <= w_aNext;
         r_b   <= w_bNext;
         r_hi  <= w_hiNext;
         r_lo  <= w_loNext;
      end
   end

   // In IDLE, a start with a MULT or DIV op latches the operands and loads
   // the latency counter. MTHI/MTLO write straight through and leave the unit
   // idle. In RUN, the counter counts down and the result is committed on the
   // 1->0 step, unless the divisor was zero. A start during RUN is ignored,
   // and so is a start with an unknown op.
   always_comb begin
      w_cntNext = r_cnt;
      w_opNext  = r_op;
      w_aNext   = r_a;
      w_bNext   = r_b;
      w_hiNext  = r_hi;
      w_loNext  = r_lo;
      w_commit  = 1'b0;

      case (w_state)
         ST_IDLE: begin
            if (md.start) begin
               if (isMultOp(md.op) || isDivOp(md.op)) begin
                  w_opNext  = md.op;
                  w_aNext   = md.rs_data;
                  w_bNext   = md.rt_data;
                  w_cntNext = isMultOp(md.op) ? MD_CNT_W'(MUL_CYCLES)
                                              : MD_CNT_W'(DIV_CYCLES);
               end else if (md.op == MD_OP_MTHI) begin
                  w_hiNext = md.rs_data;
                  w_commit = 1'b1;
               end else if (md.op == MD_OP_MTLO) begin
                  w_loNext = md.rs_data;
                  w_commit = 1'b1;
               end
            end
         end
         ST_RUN: begin
            w_cntNext = r_cnt - MD_CNT_W'(1);
            if ((r_cnt == MD_CNT_W'(1)) && !w_res.divByZero) begin
               w_hiNext = w_res.hi;
               w_loNext = w_res.lo;
               w_commit = 1'b1;
            end
         end
         default: begin
            w_cntNext = '0;
         end
      endcase
   end

`ifdef MULDIV_TRACE_EN
   // Simulation-only visibility: the commit trace, plus a warning when start
   // arrives while the unit is busy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_commit) begin
            $display("%d: hi/lo <= %h/%h", $time, w_hiNext, w_loNext);
         end
         if (md.start && w_busy) begin
            $display("%d: muldiv_ctrl warning: start while busy ignored", $time);
         end
      end
   end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed bench for muldiv_ctrl with hand-computed HI/LO values.
// Inputs are driven, and outputs sampled, on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   logic clk;
   logic reset;
   int   checkCount;
   int   failCount;
   int   cycles;

   muldiv_ctrl_if mdIf ();

   muldiv_ctrl #(
      .MUL_CYCLES (5),
      .DIV_CYCLES (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mdIf.slave)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Issue one start for one cycle, then scramble the live operand buses so
   // that any use of unlatched data shows up. Finally count the busy cycles,
   // with a bound.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, output int nBusy);
      @(negedge clk);
      mdIf.start   = 1'b1;
      mdIf.op      = op;
      mdIf.rs_data = a;
      mdIf.rt_data = b;
      @(negedge clk);
      mdIf.start   = 1'b0;
      mdIf.rs_data = 32'hDEAD_BEEF;
      mdIf.rt_data = 32'h0000_0003;
      nBusy = 0;
      while (mdIf.busy && nBusy < 300) begin
         nBusy++;
         @(negedge clk);
      end
   endtask

   initial begin
      checkCount     = 0;
      failCount      = 0;
      reset          = 1'b1;
      mdIf.start     = 1'b0;
      mdIf.op        = 3'd0;
      mdIf.rs_data   = 32'h0;
      mdIf.rt_data   = 32'h0;
      mdIf.d_uses_md = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", {31'b0, mdIf.busy}, 32'd0);
      checkOutput("reset_hi", mdIf.hi, 32'h0);
      checkOutput("reset_lo", mdIf.lo, 32'h0);
      reset = 1'b0;

      // MULT -3 * 5 = -15
      applyStimulus(MD_OP_MULT, 32'hFFFF_FFFD, 32'd5, cycles);
      checkOutput("mult_cycles", cycles, 32'd5);
      checkOutput("mult_hi", mdIf.hi, 32'hFFFF_FFFF);
      checkOutput("mult_lo", mdIf.lo, 32'hFFFF_FFF1);

      // MULTU 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
      applyStimulus(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cycles);
      checkOutput("multu_hi", mdIf.hi, 32'hFFFF_FFFE);
      checkOutput("multu_lo", mdIf.lo, 32'h0000_0001);

      // DIVU 7 / 2 = 3 rem 1
      applyStimulus(MD_OP_DIVU, 32'd7, 32'd2, cycles);
      checkOutput("divu_cycles", cycles, 32'd10);
      checkOutput("divu_lo", mdIf.lo, 32'd3);
      checkOutput("divu_hi", mdIf.hi, 32'd1);

      // DIV -7 / 2 = -3 rem -1
      applyStimulus(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, cycles);
      checkOutput("div_neg_lo", mdIf.lo, 32'hFFFF_FFFD);
      checkOutput("div_neg_hi", mdIf.hi, 32'hFFFF_FFFF);

      // DIV overflow corner
      applyStimulus(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cycles);
      checkOutput("div_ovf_lo", mdIf.lo, 32'h8000_0000);
      checkOutput("div_ovf_hi", mdIf.hi, 32'h0);

      // Divide by zero keeps the preloaded HI/LO but still takes full latency
      applyStimulus(MD_OP_MTHI, 32'h11, 32'h0, cycles);
      applyStimulus(MD_OP_MTLO, 32'h22, 32'h0, cycles);
      checkOutput("mtxx_hi", mdIf.hi, 32'h11);
      applyStimulus(MD_OP_DIV, 32'd5, 32'd0, cycles);
      checkOutput("div0_cycles", cycles, 32'd10);
      checkOutput("div0_hi", mdIf.hi, 32'h11);
      checkOutput("div0_lo", mdIf.lo, 32'h22);

      // Stall spans the start cycle and every busy cycle
      @(negedge clk);
      mdIf.start     = 1'b1;
      mdIf.op        = MD_OP_MULT;
      mdIf.rs_data   = 32'd2;
      mdIf.rt_data   = 32'd3;
      mdIf.d_uses_md = 1'b1;
      #1;
      checkOutput("stall_start", {31'b0, mdIf.md_stall}, 32'd1);
      cycles = 1;
      @(negedge clk);
      mdIf.start = 1'b0;
      while (mdIf.md_stall && cycles < 300) begin
         cycles++;
         @(negedge clk);
      end
      checkOutput("stall_cycles", cycles, 32'd6);
      checkOutput("stall_mult_lo", mdIf.lo, 32'd6);
      mdIf.d_uses_md = 1'b0;

      // MTLO in idle: one-cycle write, no busy
      applyStimulus(MD_OP_MTLO, 32'h0000_ABCD, 32'h0, cycles);
      checkOutput("mtlo_lo", mdIf.lo, 32'h0000_ABCD);
      checkOutput("mtlo_busy", {31'b0, mdIf.busy}, 32'd0);
      checkOutput("mtlo_hi", mdIf.hi, 32'h0);

      // Unknown op does nothing
      applyStimulus(3'd7, 32'h5555_5555, 32'h0, cycles);
      checkOutput("unk_busy", cycles, 32'd0);
      checkOutput("unk_lo", mdIf.lo, 32'h0000_ABCD);

      // Start while busy is ignored; the original MULT commits on schedule
      @(negedge clk);
      mdIf.start   = 1'b1;
      mdIf.op      = MD_OP_MULT;
      mdIf.rs_data = 32'd6;
      mdIf.rt_data = 32'd7;
      @(negedge clk);
      mdIf.start = 1'b0;
      cycles = 0;
      while (mdIf.busy && cycles < 300) begin
         cycles++;
         if (cycles == 2) begin
            mdIf.start   = 1'b1;
            mdIf.op      = MD_OP_MULTU;
            mdIf.rs_data = 32'hFFFF_FFFF;
            mdIf.rt_data = 32'hFFFF_FFFF;
         end else begin
            mdIf.start = 1'b0;
         end
         @(negedge clk);
      end
      mdIf.start = 1'b0;
      checkOutput("busy_start_cycles", cycles, 32'd5);
      checkOutput("busy_start_hi", mdIf.hi, 32'h0);
      checkOutput("busy_start_lo", mdIf.lo, 32'd42);

      // Reset in busy cycle 3 discards the pending MULT
      @(negedge clk);
      mdIf.start   = 1'b1;
      mdIf.op      = MD_OP_MULT;
      mdIf.rs_data = 32'd100;
      mdIf.rt_data = 32'd100;
      @(negedge clk);
      mdIf.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rst_mid_busy", {31'b0, mdIf.busy}, 32'd0);
      checkOutput("rst_mid_lo", mdIf.lo, 32'h0);
      repeat (8) @(negedge clk);
      checkOutput("rst_no_commit_lo", mdIf.lo, 32'h0);
      checkOutput("rst_no_commit_hi", mdIf.hi, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
